setassoc_wb_cache: RTL and testbench

Parametrised, blocking, N-way set-associative write-back cache that sits between the CPU load/store port and the AXI bridge's line read/write interface. It serves hits in one cycle. On a miss it evicts a victim by true LRU, writes back dirty victims through a line write port, and refills with a line burst. Write misses allocate.

---
 rtl/setassoc_wb_cache.sv | 204 ++++++++++++++++++++
 tb/tb_setassoc_wb_cache.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/setassoc_wb_cache.sv
// Blocking N-way set-associative write-back cache with true-LRU replacement.
// Arrays live in flops and are read combinationally; misses refill through a line read port.
module setassoc_wb_cache #(
    parameter int WAYS  = 2,
    parameter int SETS  = 256,
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_valid,
    input  logic                  i_op,
    input  logic [31:0]           i_addr,
    input  logic [3:0]            i_wstrb,
    input  logic [31:0]           i_wdata,
    output logic                  o_addr_ok,
    output logic                  o_data_ok,
    output logic [31:0]           o_rdata,
    output logic                  o_rd_req,
    output logic [2:0]            o_rd_type,
    output logic [31:0]           o_rd_addr,
    input  logic                  i_rd_rdy,
    input  logic                  i_ret_valid,
    input  logic                  i_ret_last,
    input  logic [31:0]           i_ret_data,
    output logic                  o_wr_req,
    output logic [2:0]            o_wr_type,
    output logic [31:0]           o_wr_addr,
    output logic [3:0]            o_wr_wstrb,
    output logic [WORDS*32-1:0]   o_wr_data,
    input  logic                  i_wr_rdy
);
    localparam int WW   = $clog2(WORDS);
    localparam int OFFW = WW + 2;
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 32 - OFFW - IDXW;
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW   = WW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_MISS, S_REFILL} state_t;
    state_t r_state, w_next;

    logic            r_op;
    logic [31:2]     r_addr;
    logic [3:0]      r_wstrb;
    logic [31:0]     r_wdata;
    logic [AW-1:0]   r_victim;
    logic [CW-1:0]   r_cnt;

    logic [WAYS-1:0] r_valid [SETS];
    logic [WAYS-1:0] r_dirty [SETS];
    logic [TAGW-1:0] r_tag   [SETS][WAYS];
    logic [31:0]     r_data  [SETS][WAYS][WORDS];
    logic [AW-1:0]   r_age   [SETS][WAYS];

    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;
    logic [WW-1:0]   w_word;
    logic            w_hit, w_inv_found;
    logic [AW-1:0]   w_hit_way, w_victim, w_acc_way;
    logic            w_beat, w_fill, w_lookup_hit;
    logic [31:0]     w_cur_word, w_req_word, w_merged;

    function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            f_merge[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    endfunction

    assign w_idx  = r_addr[OFFW+IDXW-1:OFFW];
    assign w_tag  = r_addr[31:OFFW+IDXW];
    assign w_word = r_addr[OFFW-1:2];

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_victim    = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(w);
            end
        // descending scan so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w_idx][w]) begin
                w_victim    = AW'(w);
                w_inv_found = 1'b1;
            end
        if (!w_inv_found)
            for (int w = 0; w < WAYS; w++)
                if (r_age[w_idx][w] == AW'(WAYS - 1)) w_victim = AW'(w);
    end

    assign w_lookup_hit = (r_state == S_LOOKUP) && w_hit;
    assign w_beat       = (r_state == S_REFILL) && i_ret_valid && (r_cnt < CW'(WORDS));
    assign w_fill       = (r_state == S_REFILL) && i_ret_valid && i_ret_last;
    assign w_acc_way    = w_lookup_hit ? w_hit_way : r_victim;
    assign w_cur_word   = r_data[w_idx][w_acc_way][w_word];
    assign w_req_word   = (w_beat && r_cnt[WW-1:0] == w_word) ? i_ret_data : w_cur_word;
    assign w_merged     = f_merge(w_req_word, r_wdata, r_wstrb);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_addr_ok = 1'b0;
        o_data_ok = 1'b0;
        o_rd_req  = 1'b0;
        o_wr_req  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_addr_ok = i_valid;
                if (i_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    o_data_ok = 1'b1;
                    w_next    = S_IDLE;
                end else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                    w_next = S_WRITEBACK;
                end else begin
                    w_next = S_MISS;
                end
            end
            S_WRITEBACK: begin
                o_wr_req = 1'b1;
                if (i_wr_rdy) w_next = S_MISS;
            end
            S_MISS: begin
                o_rd_req = 1'b1;
                if (i_rd_rdy) w_next = S_REFILL;
            end
            S_REFILL: begin
                if (i_ret_valid && i_ret_last) begin
                    o_data_ok = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // data and tags carry no reset; valid bits gate their use
    always_ff @(posedge i_clk) begin
        if (w_beat) r_data[w_idx][r_victim][r_cnt[WW-1:0]] <= i_ret_data;
        if ((w_lookup_hit || w_fill) && r_op) r_data[w_idx][w_acc_way][w_word] <= w_merged;
        if (w_fill) r_tag[w_idx][r_victim] <= w_tag;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_op     <= 1'b0;
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_victim <= '0;
            r_cnt    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= AW'(w);
            end
        end else begin
            if (o_addr_ok) begin
                r_op    <= i_op;
                r_addr  <= i_addr[31:2];
                r_wstrb <= i_wstrb;
                r_wdata <= i_wdata;
            end
            if (r_state == S_LOOKUP && !w_hit) r_victim <= w_victim;
            if (r_state == S_MISS && i_rd_rdy) r_cnt <= '0;
            if (w_beat) r_cnt <= r_cnt + CW'(1);
            if (w_lookup_hit && r_op) r_dirty[w_idx][w_hit_way] <= 1'b1;
            if (r_state == S_WRITEBACK && i_wr_rdy) r_valid[w_idx][r_victim] <= 1'b0;
            if (w_fill) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= r_op;
            end
            if (w_lookup_hit || w_fill)
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == w_acc_way)
                        r_age[w_idx][w] <= '0;
                    else if (r_age[w_idx][w] < r_age[w_idx][w_acc_way])
                        r_age[w_idx][w] <= r_age[w_idx][w] + AW'(1);
                end
        end
    end

    assign o_rdata    = o_data_ok ? w_req_word : '0;
    assign o_rd_type  = 3'b100;
    assign o_wr_type  = 3'b100;
    assign o_wr_wstrb = 4'hf;
    assign o_rd_addr  = o_rd_req ? {r_addr[31:OFFW], {OFFW{1'b0}}} : '0;
    assign o_wr_addr  = o_wr_req ? {r_tag[w_idx][r_victim], w_idx, {OFFW{1'b0}}} : '0;

    always_comb begin
        o_wr_data = '0;
        if (o_wr_req)
            for (int k = 0; k < WORDS; k++) o_wr_data[32*k +: 32] = r_data[w_idx][r_victim][k];
    end
endmodule

// File: tb/tb_setassoc_wb_cache.sv
// Bench for setassoc_wb_cache: directed table, reset-mid-refill sequence, random traffic
// checked against a timestamp-LRU cache model over a flat word memory.
module tb_setassoc_wb_cache;
    localparam int WAYS = 2, SETS = 256, WORDS = 4, LW = WORDS * 32;

    logic clk = 1'b0, resetn = 1'b0;
    logic valid = 1'b0, op = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0, wr_rdy = 1'b0;
    logic [31:0] ret_data = '0;
    logic addr_ok, data_ok, rd_req, wr_req;
    logic [31:0] rdata, rd_addr, wr_addr;
    logic [2:0]  rd_type, wr_type;
    logic [3:0]  wr_wstrb;
    logic [LW-1:0] wr_data;

    always #5 clk = ~clk;

    setassoc_wb_cache #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) u_dut (
        .i_clk(clk), .i_resetn(resetn), .i_valid(valid), .i_op(op), .i_addr(addr),
        .i_wstrb(wstrb), .i_wdata(wdata), .o_addr_ok(addr_ok), .o_data_ok(data_ok),
        .o_rdata(rdata), .o_rd_req(rd_req), .o_rd_type(rd_type), .o_rd_addr(rd_addr),
        .i_rd_rdy(rd_rdy), .i_ret_valid(ret_valid), .i_ret_last(ret_last),
        .i_ret_data(ret_data), .o_wr_req(wr_req), .o_wr_type(wr_type), .o_wr_addr(wr_addr),
        .o_wr_wstrb(wr_wstrb), .o_wr_data(wr_data), .i_wr_rdy(wr_rdy));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // CPU-visible memory; words never written hold a fixed pattern
    logic [31:0] mem [logic [29:0]];
    function automatic logic [31:0] f_init(input logic [29:0] wa);
        return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return f_init(wa);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // cache model: LRU victim = valid way with the oldest access timestamp
    bit          m_vld [SETS][WAYS];
    bit          m_drt [SETS][WAYS];
    logic [27:0] m_line[SETS][WAYS];
    longint      m_ts  [SETS][WAYS];
    longint      g_time;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_vld[s][w] = 0; m_drt[s][w] = 0; m_line[s][w] = '0; m_ts[s][w] = -w;
            end
        g_time = 0;
    endtask

    task automatic scramble();
        valid = 1'($urandom_range(0, 1)); op = 1'($urandom); addr = $urandom;
        wstrb = 4'($urandom); wdata = $urandom; rd_rdy = 1'b0; wr_rdy = 1'b0;
        ret_valid = 1'b0; ret_last = 1'($urandom); ret_data = $urandom;
    endtask

    task automatic chk_rst(input string tg);
        chk({tg, " addr_ok"}, addr_ok, 0);   chk({tg, " data_ok"}, data_ok, 0);
        chk({tg, " rdata"}, rdata, 0);       chk({tg, " rd_req"}, rd_req, 0);
        chk({tg, " rd_type"}, rd_type, 3'b100); chk({tg, " rd_addr"}, rd_addr, 0);
        chk({tg, " wr_req"}, wr_req, 0);     chk({tg, " wr_type"}, wr_type, 3'b100);
        chk({tg, " wr_addr"}, wr_addr, 0);   chk({tg, " wr_wstrb"}, wr_wstrb, 4'hf);
        chk({tg, " wr_data"}, wr_data, 0);
    endtask

    task automatic do_req(input bit rop, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int rs, input int gp, input int ws,
                          output bit ob_hit, output bit ob_wb, output logic [31:0] ob_wba,
                          output logic [31:0] ob_rd);
        int s, hw, vw;
        bit need_wb;
        logic [27:0] ln;
        logic [31:0] exp_rd, vaddr;
        logic [LW-1:0] exp_line;
        s = int'(a[11:4]); ln = a[31:4]; hw = -1; vw = -1;
        for (int w = 0; w < WAYS; w++) if (m_vld[s][w] && m_line[s][w] == ln) hw = w;
        for (int w = 0; w < WAYS; w++) if (!m_vld[s][w] && vw < 0) vw = w;
        if (vw < 0) begin
            vw = 0;
            for (int w = 1; w < WAYS; w++) if (m_ts[s][w] < m_ts[s][vw]) vw = w;
        end
        need_wb = (hw < 0) && m_vld[s][vw] && m_drt[s][vw];
        vaddr = {m_line[s][vw], 4'h0};
        for (int k = 0; k < WORDS; k++) exp_line[32*k +: 32] = mem_rd(vaddr[31:2] + 30'(k));
        exp_rd = mem_rd(a[31:2]);
        ob_hit = 0; ob_wb = 0; ob_wba = '0; ob_rd = '0;

        @(negedge clk); scramble(); valid = 1'b1; op = rop; addr = a; wstrb = be; wdata = wd; #1;
        chk("accept addr_ok", addr_ok, 1); chk("accept data_ok", data_ok, 0);
        @(negedge clk); scramble(); #1;
        ob_hit = data_ok; ob_rd = rdata;
        chk("lookup addr_ok", addr_ok, 0); chk("lookup hit", data_ok, hw >= 0);
        chk("lookup rd_req", rd_req, 0);   chk("lookup wr_req", wr_req, 0);
        if (hw >= 0 && !rop) chk("hit rdata", rdata, exp_rd);
        if (hw < 0) begin
            if (need_wb)
                for (int i = 0; i <= ws; i++) begin
                    @(negedge clk); scramble(); wr_rdy = (i == ws); #1;
                    if (i == 0) begin ob_wb = wr_req; ob_wba = wr_addr; end
                    chk("wb wr_req", wr_req, 1); chk("wb wr_addr", wr_addr, vaddr);
                    chk("wb wr_data", wr_data, exp_line); chk("wb rd_req", rd_req, 0);
                    chk("wb addr_ok", addr_ok, 0);
                end
            for (int i = 0; i <= rs; i++) begin
                @(negedge clk); scramble(); rd_rdy = (i == rs); #1;
                if (i == 0 && !need_wb) begin ob_wb = wr_req; ob_wba = wr_addr; end
                chk("miss rd_req", rd_req, 1); chk("miss rd_addr", rd_addr, {a[31:4], 4'h0});
                chk("miss rd_type", rd_type, 3'b100); chk("miss wr_req", wr_req, 0);
                chk("miss data_ok", data_ok, 0); chk("miss addr_ok", addr_ok, 0);
            end
            for (int k = 0; k < WORDS; k++) begin
                for (int g = 0; g < gp; g++) begin
                    @(negedge clk); scramble(); #1;
                    chk("gap data_ok", data_ok, 0); chk("gap rd_req", rd_req, 0);
                    chk("gap addr_ok", addr_ok, 0);
                end
                @(negedge clk); scramble();
                ret_valid = 1'b1; ret_last = (k == WORDS - 1); ret_data = mem_rd({a[31:4], 2'(k)}); #1;
                chk("beat data_ok", data_ok, k == WORDS - 1); chk("beat addr_ok", addr_ok, 0);
                if (k == WORDS - 1) begin
                    ob_rd = rdata;
                    if (!rop) chk("refill rdata", rdata, exp_rd);
                end
            end
        end
        g_time++;
        if (hw >= 0) begin
            m_ts[s][hw] = g_time;
            if (rop) m_drt[s][hw] = 1;
        end else begin
            m_vld[s][vw] = 1; m_line[s][vw] = ln; m_drt[s][vw] = rop; m_ts[s][vw] = g_time;
        end
        if (rop) mem[a[31:2]] = merge(exp_rd, wd, be);
    endtask

    typedef struct {
        bit op; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;
        int rs; int gp; int ws;
        bit hit; bit wb; logic [31:0] wba; bit crd; logic [31:0] rd;
    } vec_t;
    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h, wb;
        logic [31:0] wba, rd;
        model_reset();
        mem[30'h48C] = 32'h0000_00A0; mem[30'h48D] = 32'h1111_00A1;
        mem[30'h48E] = 32'h0000_00A2; mem[30'h48F] = 32'h0000_00A3;

        tbl[0]  = '{0, 32'h1234, 4'h0, 32'h0,         0, 0, 0, 0, 0, 32'h0,    1, 32'h1111_00A1};
        tbl[1]  = '{0, 32'h1234, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h1111_00A1};
        tbl[2]  = '{1, 32'h1234, 4'h3, 32'hFFFF_BEEF, 0, 0, 0, 1, 0, 32'h0,    0, 32'h0};
        tbl[3]  = '{0, 32'h1234, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h1111_BEEF};
        tbl[4]  = '{0, 32'h1230, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h0000_00A0};
        tbl[5]  = '{0, 32'h2230, 4'h0, 32'h0,         1, 1, 0, 0, 0, 32'h0,    1, f_init(30'h88C)};
        tbl[6]  = '{0, 32'h1230, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h0000_00A0};
        tbl[7]  = '{0, 32'h3230, 4'h0, 32'h0,         0, 0, 0, 0, 0, 32'h0,    1, f_init(30'hC8C)};
        tbl[8]  = '{0, 32'h1230, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h0000_00A0};
        tbl[9]  = '{1, 32'h2230, 4'hF, 32'hCAFE_0010, 0, 0, 0, 0, 0, 32'h0,    0, 32'h0};
        tbl[10] = '{0, 32'h1230, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h0000_00A0};
        tbl[11] = '{0, 32'h3230, 4'h0, 32'h0,         0, 0, 4, 0, 1, 32'h2230, 1, f_init(30'hC8C)};
        tbl[12] = '{0, 32'h4230, 4'h0, 32'h0,         5, 2, 0, 0, 1, 32'h1230, 1, f_init(30'h108C)};
        tbl[13] = '{0, 32'h1234, 4'h0, 32'h0,         0, 0, 0, 0, 0, 32'h0,    1, 32'h1111_BEEF};
        tbl[14] = '{0, 32'h1234, 4'h0, 32'h0,         0, 0, 0, 1, 0, 32'h0,    1, 32'h1111_BEEF};

        #3; chk_rst("por");
        @(negedge clk); @(negedge clk); resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_req(tbl[i].op, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].rs, tbl[i].gp, tbl[i].ws,
                   h, wb, wba, rd);
            chk($sformatf("tbl%0d hit", i), h, tbl[i].hit);
            chk($sformatf("tbl%0d wb", i), wb, tbl[i].wb);
            if (tbl[i].wb) chk($sformatf("tbl%0d wb_addr", i), wba, tbl[i].wba);
            if (tbl[i].crd) chk($sformatf("tbl%0d rdata", i), rd, tbl[i].rd);
        end

        // reset asserted after two refill beats of a clean miss
        @(negedge clk); scramble(); valid = 1'b1; op = 1'b0; addr = 32'h5234; #1;
        chk("rst-seq accept", addr_ok, 1);
        @(negedge clk); scramble(); valid = 1'b0; #1;
        chk("rst-seq lookup miss", data_ok, 0);
        @(negedge clk); scramble(); rd_rdy = 1'b1; #1;
        chk("rst-seq rd_req", rd_req, 1); chk("rst-seq rd_addr", rd_addr, 32'h5230);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); scramble(); ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'hD0 + k; #1;
            chk("rst-seq beat data_ok", data_ok, 0);
        end
        @(negedge clk); scramble(); valid = 1'b0; #1; resetn = 1'b0; #1;
        chk_rst("mid-refill");
        @(negedge clk); scramble(); valid = 1'b0; ret_valid = 1'b1; #1;
        chk_rst("held");
        @(negedge clk); resetn = 1'b1; valid = 1'b0; ret_valid = 1'b0;
        model_reset();
        do_req(0, 32'h1234, 4'h0, 32'h0, 0, 0, 0, h, wb, wba, rd);
        chk("post-reset 0x1234 miss", h, 0);
        chk("post-reset 0x1234 rdata", rd, 32'h1111_BEEF);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra;
            logic [7:0]  idx;
            case ($urandom_range(0, 3))
                0: idx = 8'h23; 1: idx = 8'h01; 2: idx = 8'h80; default: idx = 8'hFF;
            endcase
            ra = {16'h0, 4'($urandom_range(1, 4)), idx, 2'($urandom), 2'b00};
            do_req(1'($urandom), ra, 4'($urandom), $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(0, 3), h, wb, wba, rd);
        end

        @(negedge clk); scramble(); valid = 1'b0; #1;
        chk("final data_ok idle", data_ok, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
